// File: rtl/dso_trig_pkg.sv
// Shared types and helpers for the ADC edge trigger.
// Lane geometry, FSM states, channel modes, pipeline beat, threshold math.
package dso_trig_pkg;

    localparam int LANES    = 8;
    localparam int SAMPLE_W = 8;
    localparam int LANE_W   = 3;
    localparam int WORD_W   = LANES * SAMPLE_W;

    // cfg_num_ch codes; 2'b1x selects four channels
    localparam logic [1:0] CH_ONE = 2'b00;
    localparam logic [1:0] CH_TWO = 2'b01;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SEARCH,
        POST,
        DONE
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              valid;
        logic              trig;
        logic [LANE_W-1:0] lane;
        logic              done;
    } beat_t;

    // Lane k belongs to the trigger channel when k mod N == ch mod N.
    function automatic logic [LANES-1:0] member_mask(
        input logic [1:0] num_ch,
        input logic [1:0] trig_ch
    );
        logic [LANES-1:0]  m;
        logic [LANE_W-1:0] k3;
        m = '0;
        for (int k = 0; k < LANES; k++) begin
            k3 = LANE_W'(k);
            if (num_ch == CH_ONE)
                m[k] = 1'b1;
            else if (num_ch == CH_TWO)
                m[k] = (k3[0] == trig_ch[0]);
            else
                m[k] = (k3[1:0] == trig_ch);
        end
        return m;
    endfunction

    // Re-arm threshold, computed in 9 bits and saturated to 8.
    function automatic sample_t arm_threshold(
        input sample_t    level,
        input logic [6:0] hyst,
        input logic       falling
    );
        logic [SAMPLE_W:0] lv;
        logic [SAMPLE_W:0] hy;
        logic [SAMPLE_W:0] t;
        lv = {level[SAMPLE_W-1], level};
        hy = {2'b00, hyst};
        t  = falling ? (lv + hy) : (lv - hy);
        if (t[SAMPLE_W] != t[SAMPLE_W-1])
            return falling ? sample_t'(8'h7F) : sample_t'(8'h80);
        return sample_t'(t[SAMPLE_W-1:0]);
    endfunction

endpackage

// File: rtl/adc_edge_trigger_if.sv
// Output stream of the edge trigger towards adc_to_datamover.
// master: data_out, data_valid, trig_valid, trig_lane driven; slave reads.
interface adc_edge_trigger_if;
    import dso_trig_pkg::*;

    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic              trig_valid;
    logic [LANE_W-1:0] trig_lane;

    modport master (
        output data_out,
        output data_valid,
        output trig_valid,
        output trig_lane
    );

    modport slave (
        input data_out,
        input data_valid,
        input trig_valid,
        input trig_lane
    );

endinterface

// File: rtl/adc_trig_scan.sv
// Combinational 8-lane hysteresis chain, lane 0 first.
// In: word, member, level, arm_thr, falling, arm_in. Out: fire, fire_lane, arm_out.
module adc_trig_scan
    import dso_trig_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [LANES-1:0]  member,
    input  sample_t           level,
    input  sample_t           arm_thr,
    input  logic              falling,
    input  logic              arm_in,
    output logic              fire,
    output logic [LANE_W-1:0] fire_lane,
    output logic              arm_out
);

    always_comb begin
        sample_t s;
        logic    hit_fire;
        logic    hit_arm;
        logic    armed;
        armed     = arm_in;
        fire      = 1'b0;
        fire_lane = '0;
        s         = '0;
        hit_fire  = 1'b0;
        hit_arm   = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            s = $signed(word[k*SAMPLE_W +: SAMPLE_W]);
            if (falling) begin
                hit_fire = (s <= level);
                hit_arm  = (s >= arm_thr);
            end else begin
                hit_fire = (s >= level);
                hit_arm  = (s <= arm_thr);
            end
            if (member[k] && !fire) begin
                // fire test uses the flag from earlier lanes only,
                // so a sample never arms and fires itself
                if (armed && hit_fire) begin
                    fire      = 1'b1;
                    fire_lane = LANE_W'(k);
                end
                if (hit_arm)
                    armed = 1'b1;
            end
        end
        arm_out = armed;
    end

endmodule

// File: rtl/adc_edge_trigger.sv
// Edge trigger stage: frames pre/search/trigger/post words, delays data.
// Ports: adc_divclk, aresetn, adc_data, arm/force_trig/abort, cfg_*, out_if, busy, done.
module adc_edge_trigger
    import dso_trig_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int PIPE_LAT = 2
) (
    input  logic              adc_divclk,
    input  logic              aresetn,
    input  logic [WORD_W-1:0] adc_data,
    input  logic              arm,
    input  logic              force_trig,
    input  logic              abort,
    input  logic [7:0]        cfg_level,
    input  logic [7:0]        cfg_hyst,
    input  logic              cfg_falling,
    input  logic [1:0]        cfg_num_ch,
    input  logic [1:0]        cfg_trig_ch,
    input  logic [CNT_W-1:0]  cfg_pre_words,
    input  logic [CNT_W-1:0]  cfg_post_words,
    adc_edge_trigger_if.master out_if,
    output logic              busy,
    output logic              done
);

    // hysteresis is 0..127; the MSB is a don't-care
    logic unused_hyst_msb;
    assign unused_hyst_msb = cfg_hyst[7];

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              armf_q;
    logic              armf_d;
    logic [LANE_W-1:0] lane_q;

    logic              falling_q;
    sample_t           level_q;
    sample_t           thr_q;
    logic [LANES-1:0]  mask_q;
    logic [CNT_W-1:0]  post_q;

    logic              latch;
    logic              word_valid;
    logic              trig;
    logic [LANE_W-1:0] trig_lane_d;

    logic              scan_fire;
    logic [LANE_W-1:0] scan_lane;
    logic              scan_arm;

    beat_t             beat_d;
    beat_t             stage_q [PIPE_LAT];

    adc_trig_scan u_scan (
        .word      (adc_data),
        .member    (mask_q),
        .level     (level_q),
        .arm_thr   (thr_q),
        .falling   (falling_q),
        .arm_in    (armf_q),
        .fire      (scan_fire),
        .fire_lane (scan_lane),
        .arm_out   (scan_arm)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        armf_d      = armf_q;
        latch       = 1'b0;
        word_valid  = 1'b0;
        trig        = 1'b0;
        trig_lane_d = '0;
        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    latch  = 1'b1;
                    armf_d = 1'b0;
                    if (cfg_pre_words != '0) begin
                        state_d = PRE;
                        cnt_d   = cfg_pre_words;
                    end else begin
                        state_d = SEARCH;
                    end
                end
            end
            PRE: begin
                word_valid = 1'b1;
                cnt_d      = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = SEARCH;
                    armf_d  = 1'b0;
                end
            end
            SEARCH: begin
                word_valid = 1'b1;
                armf_d     = scan_arm;
                if (force_trig) begin
                    trig        = 1'b1;
                    trig_lane_d = '0;
                end else if (scan_fire) begin
                    trig        = 1'b1;
                    trig_lane_d = scan_lane;
                end
                if (trig) begin
                    if (post_q != '0) begin
                        state_d = POST;
                        cnt_d   = post_q;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            POST: begin
                word_valid = 1'b1;
                cnt_d      = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1))
                    state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // abort beats arm, trigger and done; current word is dropped
        if (abort) begin
            state_d    = IDLE;
            latch      = 1'b0;
            word_valid = 1'b0;
            trig       = 1'b0;
        end
    end

    always_ff @(posedge adc_divclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            armf_q  <= 1'b0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armf_q  <= armf_d;
            if (trig)
                lane_q <= trig_lane_d;
        end
    end

    always_ff @(posedge adc_divclk or negedge aresetn) begin
        if (!aresetn) begin
            falling_q <= 1'b0;
            level_q   <= '0;
            thr_q     <= '0;
            mask_q    <= '0;
            post_q    <= '0;
        end else if (latch) begin
            falling_q <= cfg_falling;
            level_q   <= cfg_level;
            thr_q     <= arm_threshold(cfg_level, cfg_hyst[6:0],
                                       cfg_falling);
            mask_q    <= member_mask(cfg_num_ch, cfg_trig_ch);
            post_q    <= cfg_post_words;
        end
    end

    // lane travels with every beat so trig_lane holds between triggers
    always_comb begin
        beat_d       = '0;
        beat_d.data  = adc_data;
        beat_d.valid = word_valid;
        beat_d.trig  = trig;
        beat_d.lane  = trig ? trig_lane_d : lane_q;
        beat_d.done  = (state_q == DONE) && !abort;
    end

    always_ff @(posedge adc_divclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < PIPE_LAT; i++)
                stage_q[i] <= '0;
        end else begin
            stage_q[0] <= beat_d;
            for (int i = 1; i < PIPE_LAT; i++)
                stage_q[i] <= stage_q[i-1];
        end
    end

    assign out_if.data_out   = stage_q[PIPE_LAT-1].data;
    assign out_if.data_valid = stage_q[PIPE_LAT-1].valid;
    assign out_if.trig_valid = stage_q[PIPE_LAT-1].trig;
    assign out_if.trig_lane  = stage_q[PIPE_LAT-1].lane;
    assign done              = stage_q[PIPE_LAT-1].done;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_adc_edge_trigger.sv
// Directed bench for adc_edge_trigger: scan vector table plus
// hand-built framing, abort, force and reset sequences.
module tb_adc_edge_trigger;

    logic        adc_divclk = 1'b0;
    logic        aresetn;
    logic [63:0] adc_data;
    logic        arm;
    logic        force_trig;
    logic        abort;
    logic [7:0]  cfg_level;
    logic [7:0]  cfg_hyst;
    logic        cfg_falling;
    logic [1:0]  cfg_num_ch;
    logic [1:0]  cfg_trig_ch;
    logic [15:0] cfg_pre_words;
    logic [15:0] cfg_post_words;
    logic        busy;
    logic        done;

    always #5 adc_divclk = ~adc_divclk;

    adc_edge_trigger_if bus ();

    adc_edge_trigger #(.CNT_W(16), .PIPE_LAT(2)) dut (
        .adc_divclk     (adc_divclk),
        .aresetn        (aresetn),
        .adc_data       (adc_data),
        .arm            (arm),
        .force_trig     (force_trig),
        .abort          (abort),
        .cfg_level      (cfg_level),
        .cfg_hyst       (cfg_hyst),
        .cfg_falling    (cfg_falling),
        .cfg_num_ch     (cfg_num_ch),
        .cfg_trig_ch    (cfg_trig_ch),
        .cfg_pre_words  (cfg_pre_words),
        .cfg_post_words (cfg_post_words),
        .out_if         (bus),
        .busy           (busy),
        .done           (done)
    );

    int          errs = 0;
    int          checks = 0;
    int          cyc = 0;
    int          vcount, tcount, dcount, tpos, tlane;
    int          vfirst, vlast, dcyc;
    logic        busy_at_done;
    logic [63:0] tdata;

    always @(negedge adc_divclk) begin
        cyc++;
        if (bus.data_valid) begin
            vcount++;
            if (vcount == 1)
                vfirst = cyc;
            vlast = cyc;
        end
        if (bus.trig_valid) begin
            tcount++;
            tpos  = vcount;
            tlane = int'(bus.trig_lane);
            tdata = bus.data_out;
        end
        if (done) begin
            dcount++;
            dcyc = cyc;
            busy_at_done = busy;
        end
    end

    task automatic clr();
        vcount = 0; tcount = 0; dcount = 0; tpos = -1; tlane = -1;
        vfirst = -1; vlast = -1; dcyc = -1; busy_at_done = 1'bx;
        tdata = '0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [63:0] w);
        adc_data = w;
        @(posedge adc_divclk);
        #1;
        arm = 1'b0;
        force_trig = 1'b0;
        abort = 1'b0;
    endtask

    task automatic setcfg(input logic fall, input logic [1:0] nch,
                          input logic [1:0] tch, input int lvl,
                          input int hy, input int pre, input int post);
        cfg_falling    = fall;
        cfg_num_ch     = nch;
        cfg_trig_ch    = tch;
        cfg_level      = 8'(lvl);
        cfg_hyst       = 8'(hy);
        cfg_pre_words  = 16'(pre);
        cfg_post_words = 16'(post);
    endtask

    function automatic logic [63:0] mk(input int a0, a1, a2, a3,
                                       input int a4, a5, a6, a7);
        return {8'(a7), 8'(a6), 8'(a5), 8'(a4),
                8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [63:0] fill(input int v);
        return mk(v, v, v, v, v, v, v, v);
    endfunction

    typedef struct {
        logic        fall;
        logic [1:0]  nch;
        logic [1:0]  tch;
        int          lvl;
        int          hy;
        logic [63:0] w0;
        logic [63:0] w1;
        bit          et;
        int          el;
    } vec_t;

    localparam int NV = 12;
    vec_t vt [NV];

    logic [63:0] w1, w2, w3;

    initial begin
        vt[0]  = '{1'b0, 2'b00, 2'd0, 0, 4,
                   mk(-2, 2, -2, 2, -2, 2, -2, 2),
                   mk(2, -2, 2, -2, 2, -2, 2, -2), 1'b0, 0};
        vt[1]  = '{1'b0, 2'b00, 2'd0, 0, 4, fill(-1),
                   mk(-5, 1, -1, -1, -1, -1, -1, -1), 1'b1, 1};
        vt[2]  = '{1'b0, 2'b00, 2'd0, 0, 0, fill(5),
                   mk(0, 5, 5, 5, 5, 5, 5, 5), 1'b1, 1};
        vt[3]  = '{1'b1, 2'b10, 2'd2, 0, 0,
                   mk(100, -100, 10, -100, 100, -100, 10, -100),
                   mk(-100, 100, 10, 100, -100, 100, -1, 100), 1'b1, 6};
        vt[4]  = '{1'b0, 2'b01, 2'd1, 10, 5,
                   mk(100, 3, 100, 7, 100, 7, 100, 7),
                   mk(100, 9, 100, 9, 100, 10, 100, 9), 1'b1, 5};
        vt[5]  = '{1'b0, 2'b00, 2'd0, -120, 20, fill(-127), fill(0),
                   1'b0, 0};
        vt[6]  = '{1'b0, 2'b00, 2'd0, -120, 20, fill(-127),
                   mk(-128, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1};
        vt[7]  = '{1'b1, 2'b00, 2'd0, 120, 20, fill(126),
                   mk(126, 126, 127, 0, 126, 126, 126, 126), 1'b1, 3};
        vt[8]  = '{1'b1, 2'b00, 2'd0, 120, 20, fill(126), fill(0),
                   1'b0, 0};
        vt[9]  = '{1'b0, 2'b00, 2'd0, 0, 4,
                   mk(-1, -1, -1, -1, -1, -1, -1, -5),
                   mk(0, -1, -1, -1, -1, -1, -1, -1), 1'b1, 0};
        vt[10] = '{1'b1, 2'b11, 2'd3, -10, 10,
                   mk(-128, -128, -128, 0, -128, -128, -128, -5),
                   mk(-128, -128, -128, -20, -128, -128, -128, -128),
                   1'b1, 3};
        vt[11] = '{1'b0, 2'b00, 2'd0, 0, 8'h84, fill(-4),
                   mk(-2, -2, 1, -2, -2, -2, -2, -2), 1'b1, 2};

        aresetn = 1'b0;
        adc_data = '0;
        arm = 1'b0;
        force_trig = 1'b0;
        abort = 1'b0;
        setcfg(1'b0, 2'b00, 2'd0, 0, 4, 0, 0);
        clr();
        repeat (3) @(posedge adc_divclk);
        #1;
        chk("rst data_out", bus.data_out, 64'h0);
        chk("rst valid", {bus.data_valid, bus.trig_valid}, 0);
        chk("rst lane", bus.trig_lane, 0);
        chk("rst busy/done", {busy, done}, 0);
        aresetn = 1'b1;
        repeat (2) step(64'h0);

        // scan vectors: two search words, trigger expected on the 2nd
        for (int i = 0; i < NV; i++) begin
            setcfg(vt[i].fall, vt[i].nch, vt[i].tch,
                   vt[i].lvl, vt[i].hy, 0, 0);
            clr();
            arm = 1'b1;
            step(64'h0);
            step(vt[i].w0);
            step(vt[i].w1);
            if (!vt[i].et)
                abort = 1'b1;
            step(64'h0);
            repeat (4) step(64'h0);
            chk($sformatf("vec%0d trig count", i), tcount, vt[i].et);
            chk($sformatf("vec%0d valid count", i), vcount, 2);
            chk($sformatf("vec%0d done count", i), dcount, vt[i].et);
            if (vt[i].et) begin
                chk($sformatf("vec%0d lane", i), tlane, vt[i].el);
                chk($sformatf("vec%0d trig pos", i), tpos, 2);
            end
        end

        // basic rising acquisition with one post word
        setcfg(1'b0, 2'b00, 2'd0, 0, 4, 0, 1);
        clr();
        w1 = mk(-10, -9, -8, -7, -6, -5, -4, -3);
        w2 = mk(-1, -1, -1, 1, -1, -1, -1, -1);
        w3 = 64'h0123_4567_89ab_cdef;
        arm = 1'b1;
        step(64'h0);
        chk("t1 busy after arm", busy, 1);
        step(w1);
        step(w2);
        step(w3);
        chk("t1 latency data", bus.data_out, w2);
        chk("t1 latency trig", bus.trig_valid, 1);
        repeat (6) step(64'h0);
        chk("t1 valid count", vcount, 3);
        chk("t1 trig pos", tpos, 2);
        chk("t1 lane", tlane, 3);
        chk("t1 trig data", tdata, w2);
        chk("t1 done count", dcount, 1);
        chk("t1 done timing", dcyc, vlast + 1);
        chk("t1 lane held", bus.trig_lane, 3);

        // hysteresis reject, then a real crossing
        setcfg(1'b0, 2'b00, 2'd0, 0, 4, 0, 0);
        clr();
        arm = 1'b1;
        step(64'h0);
        for (int i = 0; i < 20; i++)
            step((i % 2 == 0) ? mk(-2, 2, -2, 2, -2, 2, -2, 2)
                              : mk(2, -2, 2, -2, 2, -2, 2, -2));
        step(mk(-5, 1, -2, -2, -2, -2, -2, -2));
        repeat (5) step(64'h0);
        chk("t2 trig count", tcount, 1);
        chk("t2 trig pos", tpos, 21);
        chk("t2 lane", tlane, 1);

        // force beats a same-cycle edge at lane 5
        setcfg(1'b0, 2'b00, 2'd0, 0, 4, 0, 0);
        clr();
        arm = 1'b1;
        step(64'h0);
        step(fill(-10));
        force_trig = 1'b1;
        step(mk(-10, -10, -10, -10, -10, 5, -10, -10));
        repeat (5) step(64'h0);
        chk("force trig count", tcount, 1);
        chk("force lane", tlane, 0);
        chk("force done", dcount, 1);

        // abort during POST
        setcfg(1'b0, 2'b00, 2'd0, 0, 4, 0, 5);
        clr();
        arm = 1'b1;
        step(64'h0);
        force_trig = 1'b1;
        step(fill(-1));
        step(fill(-1));
        abort = 1'b1;
        step(fill(-1));
        repeat (8) step(fill(-1));
        chk("abort valid count", vcount, 2);
        chk("abort trig count", tcount, 1);
        chk("abort no done", dcount, 0);
        chk("abort idle", busy, 0);

        // pre=3, post=2, edge in 5th search word, arm pulses while busy
        setcfg(1'b0, 2'b00, 2'd0, 0, 4, 3, 2);
        clr();
        arm = 1'b1;
        step(64'h0);
        step(fill(-10));
        step(fill(-10));
        arm = 1'b1;
        step(fill(5));
        step(fill(1));
        step(fill(-10));
        arm = 1'b1;
        step(fill(-1));
        step(fill(-1));
        step(mk(-1, -1, -1, -1, 7, -1, -1, -1));
        step(fill(9));
        step(fill(9));
        repeat (6) step(64'h0);
        chk("t4 valid count", vcount, 10);
        chk("t4 contiguous", vlast - vfirst + 1, 10);
        chk("t4 trig count", tcount, 1);
        chk("t4 trig pos", tpos, 8);
        chk("t4 lane", tlane, 4);
        chk("t4 done count", dcount, 1);
        chk("t4 done timing", dcyc, vlast + 1);
        chk("t4 busy at done", busy_at_done, 0);

        // async reset mid-SEARCH
        setcfg(1'b0, 2'b00, 2'd0, 0, 4, 0, 0);
        clr();
        arm = 1'b1;
        step(64'h0);
        step(fill(-1));
        step(fill(-1));
        step(fill(-1));
        chk("pre-rst valid", bus.data_valid, 1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid rst data_out", bus.data_out, 64'h0);
        chk("mid rst valid/trig", {bus.data_valid, bus.trig_valid}, 0);
        chk("mid rst lane", bus.trig_lane, 0);
        chk("mid rst busy/done", {busy, done}, 0);
        #3;
        aresetn = 1'b1;
        repeat (6) step(fill(-1));
        chk("post rst no done", dcount, 0);
        chk("post rst idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
